// File: rtl/regfile.sv
// regfile: 31 x 32-bit integer register file (x0 hardwired to zero) with two
// combinational read ports, one synchronous write port and a busy scoreboard
// tracking registers that have an issued but not yet written-back producer.
//
// Parameters:
//   BYPASS_EN     1: a same-cycle write is forwarded to matching read ports
//                 0: reads return the stored value only
// Ports:
//   i_clk         clock, all state updates on rising edge
//   i_reset       synchronous active-high reset (clears registers and busy)
//   i_rs1_addr    read port 1 index      -> o_rs1_data, o_rs1_busy
//   i_rs2_addr    read port 2 index      -> o_rs2_data, o_rs2_busy
//   i_rd_wren     writeback enable
//   i_rd_addr     writeback index
//   i_rd_data     writeback value
//   i_issue_valid instruction issued this cycle with destination i_issue_rd
//   i_issue_rd    destination of the issued instruction
module regfile #(
  parameter int unsigned BYPASS_EN = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_rd_wren,
  input  logic [4:0]  i_rd_addr,
  input  logic [31:0] i_rd_data,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy
);

  localparam bit BYP = (BYPASS_EN != 0);

  // Entry 0 is only ever cleared; reads of index 0 are masked to zero anyway.
  logic [31:0] regs [32];
  logic [31:1] busy_q;
  logic [31:0] busy;
  logic        wr_en;
  logic        rs1_hit;
  logic        rs2_hit;

  assign wr_en = i_rd_wren && (i_rd_addr != 5'd0);
  assign busy  = {busy_q, 1'b0};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (wr_en) begin
        regs[i_rd_addr] <= i_rd_data;
      end
      // Issue is checked first so a new producer wins over a retiring one.
      for (int unsigned i = 1; i < 32; i++) begin
        if (i_issue_valid && (i_issue_rd == 5'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (wr_en && (i_rd_addr == 5'(i))) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  // Reads are independent of reset so operands stay combinational throughout.
  always_comb begin
    rs1_hit = BYP && wr_en && (i_rd_addr == i_rs1_addr);
    rs2_hit = BYP && wr_en && (i_rd_addr == i_rs2_addr);

    o_rs1_data = '0;
    o_rs2_data = '0;
    if (i_rs1_addr != 5'd0) begin
      o_rs1_data = rs1_hit ? i_rd_data : regs[i_rs1_addr];
    end
    if (i_rs2_addr != 5'd0) begin
      o_rs2_data = rs2_hit ? i_rd_data : regs[i_rs2_addr];
    end

    o_rs1_busy = busy[i_rs1_addr] && !rs1_hit;
    o_rs2_busy = busy[i_rs2_addr] && !rs2_hit;
  end

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

  logic        i_clk;
  logic        i_reset;
  logic [4:0]  i_rs1_addr;
  logic [4:0]  i_rs2_addr;
  logic        i_rd_wren;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_rd_data;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;

  logic [31:0] bp_rs1_data, bp_rs2_data, nb_rs1_data, nb_rs2_data;
  logic        bp_rs1_busy, bp_rs2_busy, nb_rs1_busy, nb_rs2_busy;

  regfile #(.BYPASS_EN(1)) dut_bp (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1_data(bp_rs1_data), .o_rs2_data(bp_rs2_data),
    .i_rd_wren(i_rd_wren), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
    .o_rs1_busy(bp_rs1_busy), .o_rs2_busy(bp_rs2_busy)
  );

  regfile #(.BYPASS_EN(0)) dut_nb (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1_data(nb_rs1_data), .o_rs2_data(nb_rs2_data),
    .i_rd_wren(i_rd_wren), .i_rd_addr(i_rd_addr), .i_rd_data(i_rd_data),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
    .o_rs1_busy(nb_rs1_busy), .o_rs2_busy(nb_rs2_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          bp;
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
    int          tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   tag    = 0;
  bit   done   = 1'b0;

  always @(negedge i_clk) begin
    exp_t        e;
    logic [31:0] a1, a2;
    logic        ab1, ab2;
    while (q.size() > 0) begin
      e = q.pop_front();
      if (e.bp) begin
        a1 = bp_rs1_data; a2 = bp_rs2_data; ab1 = bp_rs1_busy; ab2 = bp_rs2_busy;
      end else begin
        a1 = nb_rs1_data; a2 = nb_rs2_data; ab1 = nb_rs1_busy; ab2 = nb_rs2_busy;
      end
      checks++;
      if ({a1, a2, ab1, ab2} !== {e.d1, e.d2, e.b1, e.b2}) begin
        errors++;
        $display("FAIL chk%0d bypass=%0d got d1=%h d2=%h b1=%b b2=%b want d1=%h d2=%h b1=%b b2=%b",
                 e.tag, e.bp, a1, a2, ab1, ab2, e.d1, e.d2, e.b1, e.b2);
      end
    end
    if (done) begin
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                       input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic iv, input logic [4:0] ird, input logic rst);
    i_rs1_addr    = a1;
    i_rs2_addr    = a2;
    i_rd_wren     = we;
    i_rd_addr     = rd;
    i_rd_data     = d;
    i_issue_valid = iv;
    i_issue_rd    = ird;
    i_reset       = rst;
  endtask

  task automatic push(input bit bp, input logic [31:0] d1, input logic [31:0] d2,
                      input logic b1, input logic b2);
    exp_t e;
    e.bp = bp; e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2; e.tag = tag;
    q.push_back(e);
  endtask

  task automatic expsplit(input logic [31:0] d1, input logic [31:0] d2,
                          input logic b1, input logic b2,
                          input logic [31:0] n1, input logic [31:0] n2,
                          input logic nb1, input logic nb2);
    push(1'b1, d1, d2, b1, b2);
    push(1'b0, n1, n2, nb1, nb2);
    tag++;
  endtask

  task automatic expall(input logic [31:0] d1, input logic [31:0] d2,
                        input logic b1, input logic b2);
    expsplit(d1, d2, b1, b2, d1, d2, b1, b2);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    step();
    step();

    for (int i = 0; i < 32; i++) begin
      drive(5'(i), 5'(31 - i), 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
      expall(32'h0, 32'h0, 1'b0, 1'b0);
      step();
    end

    drive(5'd0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0);
    expall(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0);
    #1;
    checks++;
    if (nb_rs1_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL x5 read: got %h want %h", nb_rs1_data, 32'hDEADBEEF);
    end
    checks++;
    if (bp_rs2_data !== nb_rs2_data) begin
      errors++;
      $display("FAIL x5 port2 mismatch: got %h want %h", bp_rs2_data, nb_rs2_data);
    end
    step();
    drive(5'd0, 5'd5, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 1'b0);
    expall(32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    step();
    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bp_rs1_data !== 32'h0) begin
      errors++;
      $display("FAIL x0 read: got %h want %h", bp_rs1_data, 32'h0);
    end
    step();

    drive(5'd5, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    expall(32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    step();
    drive(5'd5, 5'd7, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0);
    expsplit(32'hDEADBEEF, 32'hA5A5A5A5, 1'b0, 1'b0,
             32'hDEADBEEF, 32'h0,        1'b0, 1'b1);
    #1;
    checks++;
    if (bp_rs2_data !== 32'hA5A5A5A5 || bp_rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL bypass x7: got %h/%b want %h/%b", bp_rs2_data, bp_rs2_busy, 32'hA5A5A5A5, 1'b0);
    end
    checks++;
    if (nb_rs2_data !== 32'h0 || nb_rs2_busy !== 1'b1) begin
      errors++;
      $display("FAIL no-bypass x7: got %h/%b want %h/%b", nb_rs2_data, nb_rs2_busy, 32'h0, 1'b1);
    end
    step();
    drive(5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0);
    step();

    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0);
    expall(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'h0, 32'h0, 1'b1, 1'b1);
    step();
    drive(5'd3, 5'd0, 1'b1, 5'd3, 32'h10, 1'b0, 5'd0, 1'b0);
    expsplit(32'h10, 32'h0, 1'b0, 1'b0,
             32'h0,  32'h0, 1'b1, 1'b0);
    step();
    drive(5'd3, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'h10, 32'h10, 1'b0, 1'b0);
    step();

    drive(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0);
    expall(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(5'd9, 5'd9, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 1'b0);
    expsplit(32'h99, 32'h99, 1'b0, 1'b0,
             32'h0,  32'h0,  1'b1, 1'b1);
    step();
    drive(5'd9, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0);
    expall(32'h99, 32'h0, 1'b1, 1'b0);
    #1;
    checks++;
    if (nb_rs1_busy !== 1'b1 || nb_rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL busy x9/x0: got %b/%b want %b/%b", nb_rs1_busy, nb_rs2_busy, 1'b1, 1'b0);
    end
    step();
    drive(5'd0, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'h0, 32'h99, 1'b0, 1'b1);
    step();

    drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 1'b0);
    expall(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(5'd11, 5'd12, 1'b1, 5'd12, 32'hC, 1'b1, 5'd11, 1'b0);
    expsplit(32'h0, 32'hC, 1'b0, 1'b0,
             32'h0, 32'h0, 1'b0, 1'b1);
    step();
    drive(5'd11, 5'd12, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'h0, 32'hC, 1'b1, 1'b0);
    step();

    drive(5'd0, 5'd0, 1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 1'b0);
    expall(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(5'd20, 5'd20, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'h2020, 32'h2020, 1'b0, 1'b0);
    step();

    drive(5'd0, 5'd0, 1'b1, 5'd4, 32'hFF, 1'b1, 5'd4, 1'b0);
    expall(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(5'd4, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'hFF, 32'hFF, 1'b1, 1'b1);
    step();
    drive(5'd4, 5'd6, 1'b1, 5'd4, 32'h1, 1'b1, 5'd6, 1'b1);
    expsplit(32'h1,  32'h0, 1'b0, 1'b0,
             32'hFF, 32'h0, 1'b1, 1'b0);
    step();
    drive(5'd4, 5'd6, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bp_rs1_data !== 32'h0 || bp_rs1_busy !== 1'b0 || bp_rs2_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset priority: got %h/%b/%b want %h/%b/%b",
               bp_rs1_data, bp_rs1_busy, bp_rs2_busy, 32'h0, 1'b0, 1'b0);
    end
    step();
    drive(5'd5, 5'd9, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'h0, 32'h0, 1'b0, 1'b0);
    step();
    drive(5'd11, 5'd20, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
    expall(32'h0, 32'h0, 1'b0, 1'b0);
    step();

    done = 1'b1;
    repeat (10) @(posedge i_clk);
    $display("FAIL watchdog monitor did not finish: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 The block SHALL have one parameter: BYPASS_EN, default 1, enables write-to-read forwarding in the same cycle.
REQ-002 The block SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port i_rs1_addr, input, 5 bits, source register 1 index.
REQ-005 The block SHALL have port i_rs2_addr, input, 5 bits, source register 2 index.
REQ-006 The block SHALL have port o_rs1_data, output, 32 bits, operand A to the ALU.
REQ-007 The block SHALL have port o_rs2_data, output, 32 bits, operand B to the ALU.
REQ-008 The block SHALL have port i_rd_wren, input, 1 bit, writeback enable.
REQ-009 The block SHALL have port i_rd_addr, input, 5 bits, writeback destination index.
REQ-010 The block SHALL have port i_rd_data, input, 32 bits, writeback value.
REQ-011 The block SHALL have port i_issue_valid, input, 1 bit, an instruction with destination i_issue_rd is issued this cycle.
REQ-012 The block SHALL have port i_issue_rd, input, 5 bits, destination of the issued instruction.
REQ-013 The block SHALL have port o_rs1_busy, output, 1 bit, rs1 has a pending, unwritten producer.
REQ-014 The block SHALL have port o_rs2_busy, output, 1 bit, rs2 has a pending, unwritten producer.

Function
REQ-015 The block SHALL store 31 general registers x1..x31, 32 bits each; x0 SHALL read as 32'h0 and ignore writes.
REQ-016 The block SHALL write i_rd_data into x[i_rd_addr] on the rising edge when i_rd_wren=1 and i_rd_addr!=0.
REQ-017 Reads SHALL be combinational (zero-cycle latency) from i_rsN_addr to o_rsN_data.
REQ-018 With BYPASS_EN=1, o_rsN_data SHALL equal i_rd_data when i_rd_wren=1, i_rd_addr==i_rsN_addr and i_rsN_addr!=0; otherwise it SHALL equal the stored value.
REQ-019 With BYPASS_EN=0, reads SHALL return the stored value only; a same-cycle write becomes visible the next cycle.
REQ-020 The block SHALL keep a 32-bit scoreboard busy[31:0]; busy[0] SHALL be constant 0.
REQ-021 On the rising edge, i_issue_valid=1 with i_issue_rd!=0 SHALL set busy[i_issue_rd].
REQ-022 On the rising edge, i_rd_wren=1 with i_rd_addr!=0 SHALL clear busy[i_rd_addr].
REQ-023 Simultaneous issue and write to the same index SHALL leave busy set (new producer wins); to different indices both updates SHALL apply.
REQ-024 o_rsN_busy SHALL be busy[i_rsN_addr], masked to 0 when BYPASS_EN=1 and a same-cycle write to that index is bypassed.
REQ-025 Both read ports addressing the same register SHALL return identical data and busy values.
REQ-026 Writes with i_rd_wren=1 to an index whose busy bit is 0 SHALL still update the register (no scoreboard check on write).

Reset
REQ-027 When i_reset=1 at a rising edge, all registers x1..x31 SHALL become 32'h0 and all busy bits SHALL become 0.
REQ-028 Reset SHALL take priority over writes and issues in the same cycle; neither SHALL take effect.
REQ-029 While i_reset=1, read outputs SHALL continue to follow REQ-017..REQ-019 combinationally; after reset, every read SHALL return 0 and busy 0.

Verification
REQ-030 Reset, then read all 32 indices on both ports -> every o_rsN_data=32'h0, every o_rsN_busy=0.
REQ-031 Write x5=32'hDEADBEEF; next cycle rs1=5, rs2=5 -> both data=32'hDEADBEEF; write x0=32'h1234 -> rs1=0 reads 32'h0.
REQ-032 BYPASS_EN=1: same cycle i_rd_wren=1, rd=7, data=32'hA5A5A5A5, rs2=7 -> o_rs2_data=32'hA5A5A5A5, o_rs2_busy=0; BYPASS_EN=0 -> old value, new value next cycle.
REQ-033 Issue rd=3 -> next cycle o_rs1_busy=1 for rs1=3; write x3=32'h10 -> following cycle busy=0, data=32'h10.
REQ-034 Same edge: issue rd=9 and write rd=9 (busy previously 1) -> busy[9] stays 1, x9 updated; issue rd=0 -> busy for rs1=0 stays 0.
REQ-035 With x4=32'hFF and busy[4]=1, assert i_reset together with write x4=32'h1 and issue rd=6 -> next cycle x4=0, busy[4]=0, busy[6]=0.
